// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the sequencer state encoding, the NOP opcode and the default drain bound.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        D_STALL = 3'd1,
        C_DRAIN = 3'd2,
        HALT    = 3'd3
    } state_e;

    localparam logic [3:0] NOP_OPCODE = 4'hF;

    localparam int DEF_DRAIN_CYC = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc_i pulses, sticks at all-ones.
// Ports: clk, rst_n (async, active-low), clr_i (sync clear), inc_i, cnt_o.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: turns ID-stage hazards into PC / IF/ID / ID/EX
// write-enable, flush and bubble controls (stall, call/ret drain, branch
// flush, halt). Inputs: clk, rst (async active-low), data_hazard,
// ctrl_hazard, branch_taken, pc_redirect, halt. Outputs: pc_we, ifid_we,
// ifid_flush, idex_bubble, halted, drain_err, state_dbg.
// Optional macro PIPE_STALL_PERF_EN adds stall_cycles / flush_events.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
`ifdef PIPE_STALL_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_hazard,
    input  logic             ctrl_hazard,
    input  logic             branch_taken,
    input  logic             pc_redirect,
    input  logic             halt,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic             drain_err,
`ifdef PIPE_STALL_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic [2:0]       state_dbg
);

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic pc_we_c;
    logic ifid_we_c;
    logic flush_c;
    logic bubble_c;
    logic halted_c;
    logic flush_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pc_we_c   = 1'b0;
        ifid_we_c = 1'b0;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        halted_c  = 1'b0;
        flush_evt = 1'b0;
        unique case (state_q)
            HALT: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                halted_c = 1'b1;
            end
            C_DRAIN: begin
                ifid_we_c = 1'b1;
                flush_c   = 1'b1;
                bubble_c  = 1'b1;
                // A redirect on the final cycle beats the timeout.
                if (pc_redirect) begin
                    pc_we_c = 1'b1;
                    state_d = RUN;
                end else if (cnt_q == 4'd0) begin
                    pc_we_c = 1'b1;
                    err_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // RUN and D_STALL share the RUN rules, except that a
                // persisting data hazard in D_STALL outranks ctrl_hazard.
                if (branch_taken) begin
                    pc_we_c   = 1'b1;
                    ifid_we_c = 1'b1;
                    flush_c   = 1'b1;
                    bubble_c  = 1'b1;
                    flush_evt = 1'b1;
                    state_d   = RUN;
                end else if ((state_q == D_STALL) && data_hazard) begin
                    bubble_c = 1'b1;
                    state_d  = D_STALL;
                end else if (ctrl_hazard) begin
                    ifid_we_c = 1'b1;
                    flush_c   = 1'b1;
                    flush_evt = 1'b1;
                    cnt_d     = DRAIN_INIT;
                    state_d   = C_DRAIN;
                end else if (data_hazard) begin
                    bubble_c = 1'b1;
                    state_d  = D_STALL;
                end else if (halt) begin
                    ifid_we_c = 1'b1;
                    flush_c   = 1'b1;
                    state_d   = HALT;
                end else begin
                    pc_we_c   = 1'b1;
                    ifid_we_c = 1'b1;
                    state_d   = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // While reset is held the pipe is frozen with a NOP in IF/ID.
    assign pc_we       = rst & pc_we_c;
    assign ifid_we     = rst & ifid_we_c;
    assign ifid_flush  = ~rst | flush_c;
    assign idex_bubble = ~rst | bubble_c;
    assign halted      = rst & halted_c;
    assign drain_err   = err_q;
    assign state_dbg   = state_q;

`ifdef PIPE_STALL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (1'b0),
        .inc_i (rst & bubble_c),
        .cnt_o (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (1'b0),
        .inc_i (rst & flush_evt),
        .cnt_o (flush_events)
    );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// hazard traffic compared cycle by cycle against a behavioural model.
module tb_pipe_stall_ctrl;

    localparam int DRAIN = 4;
    localparam int MAXC  = 65535;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic data_hazard = 1'b0;
    logic ctrl_hazard = 1'b0;
    logic branch_taken = 1'b0;
    logic pc_redirect = 1'b0;
    logic halt = 1'b0;
    logic pc_we, ifid_we, ifid_flush, idex_bubble, halted, drain_err;
    logic [2:0] state_dbg;
`ifdef PIPE_STALL_PERF_EN
    logic [15:0] stall_cycles, flush_events;
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural model: mode 0=run 1=stalled 2=draining 3=parked
    int m_mode = 0;
    int m_age = 0;
    bit m_err = 0;
    int stalls = 0;
    int flushes = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DRAIN_CYC(DRAIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_hazard  (data_hazard),
        .ctrl_hazard  (ctrl_hazard),
        .branch_taken (branch_taken),
        .pc_redirect  (pc_redirect),
        .halt         (halt),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .drain_err    (drain_err),
`ifdef PIPE_STALL_PERF_EN
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
`endif
        .state_dbg    (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs {pc_we, ifid_we, ifid_flush, idex_bubble, halted}
    task automatic model(input bit dh, input bit ch, input bit bt,
                         input bit pr, input bit hl, output logic [4:0] o);
        int nxt;
        nxt = m_mode;
        if (m_mode == 3) begin
            o = 5'b00111;
        end else if (m_mode == 2) begin
            o = 5'b01110;
            if (pr) begin
                o[4] = 1'b1;
                nxt = 0;
            end else if (m_age == DRAIN - 1) begin
                o[4] = 1'b1;
                m_err = 1'b1;
                nxt = 0;
            end else begin
                m_age++;
            end
        end else if (m_mode == 1 && dh && !bt) begin
            o = 5'b00010;
        end else if (bt) begin
            o = 5'b11110;
            nxt = 0;
            if (flushes < MAXC) flushes++;
        end else if (ch) begin
            o = 5'b01100;
            nxt = 2;
            m_age = 0;
            if (flushes < MAXC) flushes++;
        end else if (dh) begin
            o = 5'b00010;
            nxt = 1;
        end else if (hl) begin
            o = 5'b01100;
            nxt = 3;
        end else begin
            o = 5'b11000;
            nxt = 0;
        end
        if (o[1] && stalls < MAXC) stalls++;
        m_mode = nxt;
    endtask

    task automatic step(input bit dh, input bit ch, input bit bt,
                        input bit pr, input bit hl);
        logic [4:0] o;
        int e_mode, e_st, e_fl;
        bit e_err;
        @(negedge clk);
        data_hazard = dh;
        ctrl_hazard = ch;
        branch_taken = bt;
        pc_redirect = pr;
        halt = hl;
        #1;
        e_mode = m_mode;
        e_err = m_err;
        e_st = stalls;
        e_fl = flushes;
        model(dh, ch, bt, pr, hl, o);
        chk("outs", {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, halted}, {27'd0, o});
        chk("state", {29'd0, state_dbg}, e_mode);
        chk("drain_err", {31'd0, drain_err}, {31'd0, e_err});
`ifdef PIPE_STALL_PERF_EN
        chk("stall_cycles", {16'd0, stall_cycles}, e_st);
        chk("flush_events", {16'd0, flush_events}, e_fl);
`else
        if (e_st < 0 || e_fl < 0) $display("negative model count");
`endif
    endtask

    task automatic do_reset(input int n);
        data_hazard = 1'b0;
        ctrl_hazard = 1'b0;
        branch_taken = 1'b0;
        pc_redirect = 1'b0;
        halt = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("rst_outs", {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, halted}, 32'h06);
            chk("rst_state", {29'd0, state_dbg}, 32'd0);
            chk("rst_err", {31'd0, drain_err}, 32'd0);
`ifdef PIPE_STALL_PERF_EN
            chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
            chk("rst_flush", {16'd0, flush_events}, 32'd0);
`endif
        end
        m_mode = 0;
        m_age = 0;
        m_err = 1'b0;
        stalls = 0;
        flushes = 0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic rand_step(input int halt_odds);
        step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, halt_odds) == 0);
    endtask

    initial begin
        // Reset, then a free cycle
        do_reset(3);
        step(0, 0, 0, 0, 0);

        // Data stall for two cycles, resumes when hazard drops
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Call drain with redirect on the third drain cycle
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Drain timeout: error sets and sticks
        step(0, 1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("err_sticky", {31'd0, drain_err}, 32'd1);

        // Redirect on the last drain cycle leaves error clear
        do_reset(1);
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("err_clear", {31'd0, drain_err}, 32'd0);

        // Branch beats data hazard while stalled; ctrl held off by stall
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);

        // Halt, then random traffic cannot unpark
        do_reset(2);
        step(0, 0, 0, 0, 1);
        repeat (30) rand_step(3);
        chk("halted", {31'd0, halted}, 32'd1);

        // Random segments separated by resets of random length
        for (int s = 0; s < 25; s++) begin
            do_reset($urandom_range(1, 3));
            repeat ($urandom_range(50, 200)) rand_step(60);
        end

`ifdef PIPE_STALL_PERF_EN
        // Park and let the bubble counter run into saturation
        do_reset(1);
        step(0, 0, 0, 0, 1);
        repeat (MAXC + 4) rand_step(1);
        chk("stall_sat", {16'd0, stall_cycles}, 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Pipeline sequencer for the 5-stage core. It turns decode-stage hazard indications into write-enable, flush and bubble controls for the PC, IF/ID and ID/EX registers.
- Data hazards: freezes fetch/decode and inserts bubbles.
- call/ret: drains the pipe until the EX/MEM redirect (PC_update) arrives.
- Taken branches: flushes the wrong-path instructions.
- HLT: parks the pipe.
Its idex_bubble output drives the ID stage's PC_hazard_in.

Parameters:
DRAIN_CYC, 4, maximum cycles spent in C_DRAIN waiting for pc_redirect before timeout (range 1..15).
CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
clk  in  1  global clock, rising edge.
rst  in  1  asynchronous, active-low reset.
data_hazard  in  1  RAW hazard from the hazard detection unit, for the instruction in ID.
ctrl_hazard  in  1  call or ret decoded in ID.
branch_taken  in  1  taken branch resolved in EX.
pc_redirect  in  1  call/ret target loaded into PC (PC_update).
halt  in  1  HLT decoded in ID.
pc_we  out  1  PC register write enable.
ifid_we  out  1  IF/ID register write enable.
ifid_flush  out  1  IF/ID register loads a NOP.
idex_bubble  out  1  zero ID control signals into ID/EX (to PC_hazard_in).
halted  out  1  core parked.
drain_err  out  1  sticky flag: C_DRAIN timed out.
state_dbg  out  3  current state encoding.

Behaviour:
- States: RUN=0, D_STALL=1, C_DRAIN=2, HALT=3.
- Outputs are combinational from the state and the current-cycle inputs; state and counter are registered.
- While rst=0 (asynchronous assertion):
  - state=RUN, drain_cnt=0, drain_err=0.
  - Outputs forced to pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, halted=0.
- Reset release mid-stall or mid-drain returns to RUN with no residual counter state.
- RUN, with input priority branch_taken > ctrl_hazard > data_hazard > halt:
  - branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; stay in RUN. Both wrong-path slots are killed in one cycle.
  - ctrl_hazard: pc_we=0, ifid_flush=1, idex_bubble=0 (the call/ret itself advances). Next state C_DRAIN, drain_cnt<=DRAIN_CYC-1.
  - data_hazard: pc_we=0, ifid_we=0, idex_bubble=1. Next state D_STALL.
  - halt: pc_we=0, ifid_flush=1, idex_bubble=0 (HLT advances). Next state HALT.
  - none of the above: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- D_STALL:
  - branch_taken: behaves as in RUN; next state RUN.
  - data_hazard still 1: hold outputs pc_we=0, ifid_we=0, idex_bubble=1; stay in D_STALL.
  - data_hazard 0: use RUN output/transition rules for this cycle (ctrl_hazard and halt are evaluated here, so there is no lost cycle).
- C_DRAIN:
  - Outputs pc_we=0, ifid_flush=1, idex_bubble=1. branch_taken, data_hazard, ctrl_hazard and halt are ignored.
  - pc_redirect=1: pc_we=1 this cycle; next state RUN.
  - Else if drain_cnt==0: set drain_err=1 (sticky until reset), pc_we=1; next state RUN.
  - Else drain_cnt decrements.
  - If pc_redirect and drain_cnt==0 coincide, pc_redirect wins and drain_err is not set.
- HALT:
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, halted=1.
  - All inputs are ignored; only reset exits.
- Invariant: ifid_we=0 and ifid_flush=1 never occur together except in HALT and reset; in those cases flush takes precedence at the register.
- state_dbg mirrors the state register.

Optional Feature:
Macro: PIPE_STALL_PERF_EN.
- When defined, add outputs:
  - stall_cycles[CNT_W-1:0]: increments on every cycle with idex_bubble=1 outside reset.
  - flush_events[CNT_W-1:0]: increments on each branch_taken flush and on each C_DRAIN entry.
- Both counters saturate at all-ones, clear on reset, and are registered (value visible the cycle after the event).
- When undefined, these ports and counters do not exist and the rest of the behaviour is unchanged.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum typedef (3-bit);
  - localparam NOP_OPCODE=4'hF;
  - the default DRAIN_CYC.
- One natural sub-module, sat_counter (parameterised width, inc, clear, saturating), instantiated twice under PIPE_STALL_PERF_EN.
- The FSM and drain counter stay in pipe_stall_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → pc_we=0, ifid_flush=1 and idex_bubble=1 while held; state_dbg=0 and pc_we=1 on the first free cycle.
- Data stall: data_hazard=1 for 2 cycles → pc_we=0, ifid_we=0, idex_bubble=1 for exactly 2 cycles, state_dbg=1; RUN outputs resume on the cycle hazard drops.
- Call drain: ctrl_hazard pulse, then pc_redirect 3 cycles later (DRAIN_CYC=4) → 3 cycles in C_DRAIN with idex_bubble=1; pc_we=1 on the redirect cycle; drain_err=0.
- Drain timeout: ctrl_hazard with no pc_redirect → exit after 4 C_DRAIN cycles, drain_err=1 and stays 1 until reset; a redirect on the last cycle leaves drain_err=0.
- Priority: branch_taken and data_hazard asserted in the same cycle in D_STALL → ifid_flush=1, pc_we=1, next state RUN.
- Halt/perf: halt pulse then random hazards → halted=1 and pc_we=0 permanently. With PIPE_STALL_PERF_EN, stall_cycles counts each bubble cycle and saturates at 16'hFFFF.
